smachine_core: RTL

- Parametrised successor to the S-machine: a multi-cycle, load/store CPU core.
- Replaces the fixed A/B pair with an NREG x DW register file and keeps a ZNC flag register.
- Fetches and accesses data through req/ack memory ports, so instruction and data memory may insert wait states.
- Adds synchronous reset, a HALT state, conditional branches and a debug read port.

---
 rtl/smachine_pkg.sv | 42 ++++
 rtl/smachine_alu.sv | 73 +++++++
 rtl/smachine_core.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/smachine_pkg.sv
// smachine_pkg: opcodes, branch conditions, FSM states and flag bit
// indices shared by the S-machine core and its ALU.
package smachine_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hA;
  localparam logic [3:0] OP_LD   = 4'hB;
  localparam logic [3:0] OP_ST   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_Z  = 4'd1;
  localparam logic [3:0] CC_N  = 4'd2;
  localparam logic [3:0] CC_C  = 4'd3;
  localparam logic [3:0] CC_NZ = 4'd4;

  localparam int ZF = 2;
  localparam int NF = 1;
  localparam int CF = 0;

  // LDI through CMP are the only ops that touch ZNC in EXEC.
  function automatic logic sets_flags(input logic [3:0] op);
    return (op >= OP_LDI) && (op <= OP_CMP);
  endfunction

endpackage

// File: rtl/smachine_alu.sv
// smachine_alu: combinational ALU. In: op, a (rd), b (rs or imm), c_in.
// Out: result, z, n, c (c_in passes through when untouched), we.
module smachine_alu
  import smachine_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          c_in,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          n,
  output logic          c,
  output logic          we
);

  logic [DW:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = c_in;
    we     = 1'b0;
    unique case (1'b1)
      op == OP_LDI: begin
        result = b;
        we     = 1'b1;
      end
      op == OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DW-1:0];
        c      = sum[DW];
        we     = 1'b1;
      end
      op == OP_SUB, op == OP_CMP: begin
        result = a - b;
        c      = a < b;
        we     = op == OP_SUB;
      end
      op == OP_AND: begin
        result = a & b;
        c      = 1'b0;
        we     = 1'b1;
      end
      op == OP_OR: begin
        result = a | b;
        c      = 1'b0;
        we     = 1'b1;
      end
      op == OP_XOR: begin
        result = a ^ b;
        c      = 1'b0;
        we     = 1'b1;
      end
      op == OP_SHL: begin
        result = {a[DW-2:0], 1'b0};
        c      = a[DW-1];
        we     = 1'b1;
      end
      op == OP_SHR: begin
        result = {1'b0, a[DW-1:1]};
        c      = a[0];
        we     = 1'b1;
      end
      default: ;
    endcase
    z = result == '0;
    n = result[DW-1];
  end

endmodule

// File: rtl/smachine_core.sv
// smachine_core: multi-cycle load/store CPU, FETCH/EXEC/MEM/HALT FSM,
// req/ack instruction and data ports, debug register read, ZNC flags.
module smachine_core
  import smachine_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 4,
  parameter int AW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [7:0]    dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  input  logic [3:0]    dbg_sel,
  output logic [DW-1:0] dbg_reg,
  output logic [2:0]    znc_out,
  output logic [15:0]   opcode_out,
  output logic [AW-1:0] pc_out,
  output logic          halted
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] pc;
  logic [15:0]   ir;
  logic [2:0]    znc;
  logic          boot;
  logic [DW-1:0] regs [NREG];

  logic [3:0]    op;
  logic [3:0]    cc;
  logic [RW-1:0] rd;
  logic [RW-1:0] rs;
  logic [7:0]    imm;
  logic          taken;
  logic          fetch_hs;
  logic          mem_hs;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_res;
  logic          alu_z;
  logic          alu_n;
  logic          alu_c;
  logic          alu_we;
  logic          unused_dbg;

  assign op  = ir[15:12];
  assign cc  = ir[11:8];
  assign rd  = ir[8 +: RW];
  assign rs  = ir[4 +: RW];
  assign imm = ir[7:0];

  assign alu_b = (op == OP_LDI) ? DW'($signed(imm)) : regs[rs];

  smachine_alu #(.DW(DW)) u_alu (
    .op     (op),
    .a      (regs[rd]),
    .b      (alu_b),
    .c_in   (znc[CF]),
    .result (alu_res),
    .z      (alu_z),
    .n      (alu_n),
    .c      (alu_c),
    .we     (alu_we)
  );

  always_comb begin
    taken = 1'b0;
    unique case (cc)
      CC_AL:   taken = 1'b1;
      CC_Z:    taken = znc[ZF];
      CC_N:    taken = znc[NF];
      CC_C:    taken = znc[CF];
      CC_NZ:   taken = !znc[ZF];
      default: taken = 1'b0;
    endcase
  end

  assign fetch_hs = imem_req && imem_ack;
  assign mem_hs   = dmem_req && dmem_ack;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: if (fetch_hs) state_nx = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          op == OP_LD, op == OP_ST: state_nx = S_MEM;
          op == OP_HALT:            state_nx = S_HALT;
          default:                  state_nx = S_FETCH;
        endcase
      end
      S_MEM:   if (mem_hs) state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // boot masks the fetch request for the first cycle after reset.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    unique case (state)
      S_FETCH: imem_req = !boot;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = op == OP_ST;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= '0;
      ir   <= '0;
      znc  <= '0;
      boot <= 1'b1;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      boot <= 1'b0;
      if (fetch_hs) begin
        ir <= imem_rdata;
        pc <= pc + AW'(1);
      end
      if (state == S_EXEC) begin
        if (alu_we) regs[rd] <= alu_res;
        if (sets_flags(op)) znc <= {alu_z, alu_n, alu_c};
        if (op == OP_BR && taken) pc <= AW'(imm);
      end
      if (state == S_MEM && mem_hs && op == OP_LD) begin
        regs[rd] <= dmem_rdata;
        znc[ZF]  <= dmem_rdata == '0;
        znc[NF]  <= dmem_rdata[DW-1];
      end
    end
  end

  assign imem_addr  = pc;
  assign dmem_addr  = imm;
  assign dmem_wdata = regs[rd];
  assign dbg_reg    = regs[dbg_sel[RW-1:0]];
  assign znc_out    = znc;
  assign opcode_out = ir;
  assign pc_out     = pc;
  assign unused_dbg = ^dbg_sel;

endmodule
